// File: rtl/credit_display_driver.sv
// credit_display_driver: converts binary credits to BCD with a double-dabble engine and scans them onto a 5-digit active-low 7-segment display
// Ports: clk, reset (async, active-high); win_credits/is_win and total_credits/is_total are one-cycle capture strobes;
//        select is the active-low one-hot digit enable (bit 0 ones .. bit 3 thousands, bit 4 mode letter);
//        seven_segment_output is {g,f,e,d,c,b,a} active-low; busy = converter not idle; win_active = WIN display mode.
// Option: define CREDIT_WIN_BLINK_EN to blink the win digits with a BLINK_DIV-cycle half-period.
module credit_display_driver #(
  parameter int unsigned SCAN_DIV  = 25500,
  parameter int unsigned WIN_HOLD  = 76500000,
  parameter int unsigned BLINK_DIV = 6375000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] win_credits,
  input  logic        is_win,
  input  logic [11:0] total_credits,
  input  logic        is_total,
  output logic [4:0]  select,
  output logic [6:0]  seven_segment_output,
  output logic        busy,
  output logic        win_active
);
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int HW = $clog2(WIN_HOLD + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [HW-1:0] HOLD = HW'(WIN_HOLD);
  if (SCAN_DIV == 0 || WIN_HOLD == 0 || BLINK_DIV == 0) begin : g_bad_param
    $error("credit_display_driver: SCAN_DIV, WIN_HOLD and BLINK_DIV must be nonzero");
  end
  typedef enum logic [1:0] {IDLE, CONVERT, WRITE} state_t;
  state_t state, next_state;
  logic [11:0] win_bin, total_bin;
  logic pend_win, pend_total, cur_win, start, done, blink, blank;
  logic [27:0] shreg, adj;
  logic [3:0] bit_cnt, digit;
  logic [15:0] win_bcd, total_bcd, shown;
  logic [HW-1:0] hold_cnt;
  logic [SW-1:0] scan_cnt;
  logic [2:0] idx;
  logic [6:0] seg_next;
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'b1000000;
      4'd1: seg7 = 7'b1111001;
      4'd2: seg7 = 7'b0100100;
      4'd3: seg7 = 7'b0110000;
      4'd4: seg7 = 7'b0011001;
      4'd5: seg7 = 7'b0010010;
      4'd6: seg7 = 7'b0000010;
      4'd7: seg7 = 7'b1111000;
      4'd8: seg7 = 7'b0000000;
      4'd9: seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction
  // The result is stored on the edge that leaves CONVERT; WRITE is the one-cycle settle before IDLE.
  always_comb begin
    start = state == IDLE && (pend_win || pend_total);
    done = state == CONVERT && bit_cnt == 4'd12;
    next_state = start ? CONVERT : done ? WRITE : state == WRITE ? IDLE : state;
  end
  always_comb begin
    adj = shreg;
    for (int i = 0; i < 4; i++)
      adj[12 + 4*i +: 4] = adj[12 + 4*i +: 4] >= 4'd5 ? adj[12 + 4*i +: 4] + 4'd3 : adj[12 + 4*i +: 4];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next_state;
  // A strobe landing on the same edge as the load re-arms its pend flag, so the newer value is converted next.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_bin <= '0;
      total_bin <= '0;
      pend_win <= 1'b0;
      pend_total <= 1'b0;
      cur_win <= 1'b0;
      shreg <= '0;
      bit_cnt <= '0;
      win_bcd <= '0;
      total_bcd <= '0;
    end else begin
      if (is_win) win_bin <= win_credits;
      if (is_total) total_bin <= total_credits;
      pend_win <= is_win || (pend_win && !start);
      pend_total <= is_total || (pend_total && !(start && !pend_win));
      if (start) begin
        shreg <= {16'd0, pend_win ? win_bin : total_bin};
        cur_win <= pend_win;
        bit_cnt <= '0;
      end else if (state == CONVERT && !done) begin
        shreg <= {adj[26:0], 1'b0};
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (done && cur_win) win_bcd <= shreg[27:12];
      if (done && !cur_win) total_bcd <= shreg[27:12];
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      win_active <= 1'b0;
      hold_cnt <= '0;
    end else if (done && cur_win) begin
      win_active <= 1'b1;
      hold_cnt <= HOLD;
    end else if (win_active) begin
      hold_cnt <= hold_cnt - HW'(1);
      if (hold_cnt == HW'(1)) win_active <= 1'b0;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      scan_cnt <= '0;
      idx <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      idx <= idx == 3'd4 ? 3'd0 : idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
`ifdef CREDIT_WIN_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  logic [BW-1:0] blink_cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      blink_cnt <= '0;
      blink <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink <= ~blink;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
`else
  assign blink = 1'b0;
`endif
  always_comb begin
    shown = win_active ? win_bcd : total_bcd;
    digit = shown[{idx[1:0], 2'b00} +: 4];
    blank = (win_active && blink) || (idx == 3'd3 && shown[15:12] == 4'd0) ||
            (idx == 3'd2 && shown[15:8] == 8'd0) || (idx == 3'd1 && shown[15:4] == 12'd0);
    seg_next = idx == 3'd4 ? (win_active ? 7'b0001100 : 7'b0000111) : blank ? 7'b1111111 : seg7(digit);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      select <= 5'b11111;
      seven_segment_output <= 7'b1111111;
    end else begin
      select <= ~(5'b00001 << idx);
      seven_segment_output <= seg_next;
    end
  assign busy = state != IDLE;
endmodule

// File: tb/tb_credit_display_driver.sv
// tb_credit_display_driver: vector table, directed corner cases and randomized last-value model for credit_display_driver
module tb_credit_display_driver;
  localparam int SCAN_DIV = 4, WIN_HOLD = 100, BLINK_DIV = 8;
  typedef struct { logic w; logic [11:0] v; logic [31:0] d; } vec_t;
  typedef struct { logic [4:0] sel; logic [6:0] seg; } scan_t;
  logic clk = 1'b0, reset = 1'b1;
  logic [11:0] win_credits = '0, total_credits = '0;
  logic is_win = 1'b0, is_total = 1'b0;
  logic [4:0] select;
  logic [6:0] seven_segment_output;
  logic busy, win_active;
  int errors = 0, checks = 0;
  int unsigned cyc = 0, rise_c = 0, hold_len = 0;
  logic wa_q = 1'b0;
  logic bz [64];
  logic wz [64];
  logic [6:0] lut [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  credit_display_driver #(.SCAN_DIV(SCAN_DIV), .WIN_HOLD(WIN_HOLD), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .reset(reset), .win_credits(win_credits), .is_win(is_win),
    .total_credits(total_credits), .is_total(is_total), .select(select),
    .seven_segment_output(seven_segment_output), .busy(busy), .win_active(win_active));

  always #5 clk = ~clk;
  always @(posedge clk or posedge reset) cyc <= reset ? 0 : cyc + 1;
  always @(negedge clk) begin
    if (win_active && !wa_q) rise_c = cyc;
    if (!win_active && wa_q) hold_len = cyc - rise_c;
    wa_q = win_active;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] disp(input int v);
    logic [31:0] r = '0;
    int p = 1;
    for (int k = 0; k < 4; k++) begin
      r[8*k +: 8] = (k > 0 && v < p) ? 8'h20 : 8'(8'h30 + (v / p) % 10);
      p *= 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] exp_seg(input int k, input logic w, input logic [31:0] d);
    logic [7:0] ch;
    if (k == 4) return w ? 7'b0001100 : 7'b0000111;
`ifdef CREDIT_WIN_BLINK_EN
    if (w && ((cyc - 1) / BLINK_DIV) % 2 == 1) return 7'h7f;
`endif
    ch = d[8*k +: 8];
    return ch == 8'h20 ? 7'h7f : lut[int'(ch) - 48];
  endfunction

  task automatic check_display(input logic w, input logic [31:0] d);
    logic [4:0] seen;
    seen = '0;
    chk("display mode", win_active, w);
    for (int n = 0; n < 5 * SCAN_DIV; n++) begin
      int f;
      logic [4:0] m;
      f = -1;
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
        m = 5'b1 << k;
        if (select == ~m) f = k;
      end
      chk("select one-hot", 32'(f >= 0), 1);
      if (f >= 0) begin
        seen[f] = 1'b1;
        chk($sformatf("seg digit%0d val '%s'", f, d), seven_segment_output, exp_seg(f, w, d));
      end
    end
    chk("scan covers all digits", seen, 5'h1f);
  endtask

  task automatic strobe(input logic w, input logic [11:0] wv, input logic t, input logic [11:0] tv);
    is_win = w;
    win_credits = wv;
    is_total = t;
    total_credits = tv;
    @(negedge clk);
    is_win = 1'b0;
    is_total = 1'b0;
  endtask

  task automatic trace(input int len, input int inj, input logic [11:0] v);
    for (int i = 0; i < len; i++) begin
      bz[i] = busy;
      wz[i] = win_active;
      is_win = i == inj;
      if (i == inj) win_credits = v;
      @(negedge clk);
    end
    is_win = 1'b0;
  endtask

  task automatic wait_hold;
    int n = 0;
    while (win_active && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("hold expires", win_active, 0);
    @(negedge clk);
    chk("hold length", hold_len, WIN_HOLD);
  endtask

  task automatic wait_idle;
    int q = 0, n = 0;
    while (q < 3 && n < 800) begin
      @(negedge clk);
      q = busy ? 0 : q + 1;
      n++;
    end
    chk("converter settles", 32'(q >= 3), 1);
    n = 0;
    while (win_active && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("win hold ends", win_active, 0);
  endtask

  task automatic chk_reset_outputs;
    chk("reset select", select, 5'b11111);
    chk("reset seg", seven_segment_output, 7'h7f);
    chk("reset busy", busy, 0);
    chk("reset win_active", win_active, 0);
  endtask

  task automatic conv_check(input vec_t t);
    int nb = 0;
    strobe(t.w, t.v, !t.w, t.v);
    trace(16, -1, 12'd0);
    for (int i = 0; i < 16; i++) nb += int'(bz[i]);
    chk("busy cycles", nb, 14);
    chk("busy rises at E1", {bz[0], bz[1]}, 2'b01);
    chk("busy falls at E15", {bz[14], bz[15]}, 2'b10);
    chk("win_active at write", {wz[13], wz[14]}, t.w ? 2'b01 : 2'b00);
    check_display(t.w, t.d);
    if (t.w) wait_hold;
  endtask

  initial begin
    vec_t vt [11];
    scan_t sc [5];
    int last_total;
    vt = '{'{1'b0, 12'd4095, "4095"}, '{1'b0, 12'd0, "   0"}, '{1'b0, 12'd120, " 120"},
           '{1'b0, 12'd1000, "1000"}, '{1'b0, 12'd9, "   9"}, '{1'b0, 12'd305, " 305"},
           '{1'b0, 12'd10, "  10"}, '{1'b0, 12'd99, "  99"}, '{1'b1, 12'd7, "   7"},
           '{1'b1, 12'd4000, "4000"}, '{1'b0, 12'd1, "   1"}};
    sc = '{'{5'b11110, 7'h40}, '{5'b11101, 7'h7f}, '{5'b11011, 7'h7f}, '{5'b10111, 7'h7f}, '{5'b01111, 7'h07}};
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    reset = 1'b0;
    for (int e = 0; e < 5; e++)
      repeat (SCAN_DIV) begin
        @(negedge clk);
        chk($sformatf("scan select %0d", e), select, sc[e].sel);
        chk($sformatf("scan seg %0d", e), seven_segment_output, sc[e].seg);
      end
    for (int i = 0; i < 11; i++) conv_check(vt[i]);
    // total 120, then a win three cycles later queues behind it
    strobe(1'b0, 12'd0, 1'b1, 12'd120);
    trace(60, 2, 12'd7);
    chk("queued: idle gap at E15", {bz[14], bz[15], bz[16]}, 3'b101);
    chk("queued: win written at E29", {wz[28], wz[29]}, 2'b01);
    check_display(1'b1, "   7");
    wait_hold();
    check_display(1'b0, " 120");
    // simultaneous strobes: win first, total right after
    strobe(1'b1, 12'd35, 1'b1, 12'd300);
    trace(40, -1, 12'd0);
    chk("simul: win written at E14", {wz[13], wz[14]}, 2'b01);
    chk("simul: idle gap at E15", {bz[14], bz[15], bz[16]}, 3'b101);
    chk("simul: total done at E30", {bz[29], bz[30]}, 2'b10);
    check_display(1'b1, "  35");
    wait_hold();
    check_display(1'b0, " 300");
    // reset during CONVERT
    strobe(1'b0, 12'd0, 1'b1, 12'd777);
    repeat (5) @(negedge clk);
    chk("busy before reset", busy, 1);
    reset = 1'b1;
    #1 chk_reset_outputs();
    @(negedge clk);
    reset = 1'b0;
    check_display(1'b0, "   0");
    chk("no work after reset", busy, 0);
    // reset during WIN hold
    strobe(1'b1, 12'd123, 1'b0, 12'd0);
    repeat (40) @(negedge clk);
    chk("win before reset", win_active, 1);
    reset = 1'b1;
    #1 chk_reset_outputs();
    @(negedge clk);
    reset = 1'b0;
    check_display(1'b0, "   0");
    // randomized bursts against a last-value-wins model
    last_total = 0;
    for (int r = 0; r < 8; r++) begin
      int nb, fv;
      nb = $urandom_range(1, 5);
      for (int s = 0; s < nb; s++) begin
        int kind, v, sel;
        repeat ($urandom_range(0, 15)) @(negedge clk);
        kind = $urandom_range(0, 2);
        sel = $urandom_range(0, 9);
        v = sel == 0 ? 0 : sel == 1 ? 4095 : $urandom_range(0, 4095);
        if (kind != 1) last_total = v;
        strobe(kind != 0, 12'(4095 - v), kind != 1, 12'(v));
      end
      wait_idle();
      check_display(1'b0, disp(last_total));
      fv = $urandom_range(0, 4095);
      strobe(1'b1, 12'(fv), 1'b0, 12'd0);
      repeat (15) @(negedge clk);
      check_display(1'b1, disp(fv));
      wait_hold();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
